// File: rtl/dog_pkg.sv
`default_nettype none
// ============================================================================
// Module : dog_pkg
// Brief  : Shared types and helpers for the DoG extremum detector.
//          - DATA_W_DEF : default signed DoG sample width
//          - sample_t   : signed sample of the default width
//          - clog2      : address/coordinate width helper (minimum 1)
//          - abs_sat    : magnitude of a sign-extended w-bit value, clipped
//                         to the largest positive w-bit value
// Rev    : 1.0  initial release
// ============================================================================
package dog_pkg;

  localparam int DATA_W_DEF = 17;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // v carries a w-bit signed sample sign-extended to 64 bits. The only value
  // whose magnitude does not fit in w-1 bits is the most negative one; it is
  // clipped to 2^(w-1)-1 so the result always fits a w-bit unsigned field.
  function automatic logic [63:0] abs_sat(input logic signed [63:0] v,
                                          input int unsigned w);
    logic [63:0] mag;
    logic [63:0] maxp;
    maxp = (64'd1 << (w - 1)) - 64'd1;
    mag  = v[63] ? -v : v;
    return (mag > maxp) ? maxp : mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dog_line_buffer.sv
`default_nettype none
// ============================================================================
// Module : dog_line_buffer
// Brief  : Two-line delay for one DoG layer. Each column entry holds the
//          samples of the previous two lines; a write at a column pushes the
//          new sample in and ages the older one out.
// Ports  : clk   - clock
//          wr_en - accept a sample (read and write happen at addr)
//          addr  - current column
//          din   - new sample (current line)
//          tap1  - sample at addr from one line above
//          tap2  - sample at addr from two lines above
// Rev    : 1.0  initial release
// ============================================================================
module dog_line_buffer
  import dog_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 640,
  parameter int ADDR_W = clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  // Packed as {two lines up, one line up}. No reset: every entry read for a
  // valid window has been rewritten earlier in the same frame.
  logic [2*DATA_W-1:0] mem [IMG_W];
  logic [2*DATA_W-1:0] rd;

  assign rd   = mem[addr];
  assign tap1 = rd[DATA_W-1:0];
  assign tap2 = rd[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= {tap1, din};
  end

endmodule
`default_nettype wire

// File: rtl/dog_extrema_stream.sv
`default_nettype none
// ============================================================================
// Module : dog_extrema_stream
// Brief  : Streaming 3-scale DoG local-extremum detector. Builds a 3x3x3
//          window from three raster-order layers and flags the centre as a
//          keypoint candidate when it is a strict extremum over all 26
//          neighbours and its magnitude exceeds THRESH.
// Ports  : clk, rst (async, active-low)
//          in_valid, in_sof           - beat qualifier, first pixel of frame
//          dog_lo, dog_mid, dog_hi    - signed samples, lower/centre/upper
//          out_valid, keypoint        - window evaluated, candidate flag
//          kp_x, kp_y                 - centre coordinates (held when idle)
//          kp_count                   - saturating per-frame keypoint count
//          frame_done                 - pulse with the frame's last window
// Rev    : 1.0  initial release
// ============================================================================
module dog_extrema_stream
  import dog_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int THRESH = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] dog_lo,
  input  logic signed [DATA_W-1:0] dog_mid,
  input  logic signed [DATA_W-1:0] dog_hi,
  output logic                     out_valid,
  output logic                     keypoint,
  output logic [clog2(IMG_W)-1:0]  kp_x,
  output logic [clog2(IMG_H)-1:0]  kp_y,
  output logic [CNT_W-1:0]         kp_count,
  output logic                     frame_done
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);

  localparam logic [XW-1:0]     COL_ONE  = XW'(1);
  localparam logic [XW-1:0]     COL_TWO  = XW'(2);
  localparam logic [XW-1:0]     COL_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0]     COL_END  = XW'(IMG_W - 2);
  localparam logic [YW-1:0]     ROW_ONE  = YW'(1);
  localparam logic [YW-1:0]     ROW_TWO  = YW'(2);
  localparam logic [YW-1:0]     ROW_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0]     ROW_END  = YW'(IMG_H - 2);
  localparam logic [DATA_W-1:0] THR      = DATA_W'(THRESH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Raster position. A start-of-frame beat is (0,0) whatever the counters say.
  // --------------------------------------------------------------------------
  logic [XW-1:0] col, cur_col;
  logic [YW-1:0] row, cur_row;
  logic          sof_beat;
  logic          win_ok;

  assign sof_beat = in_valid & in_sof;
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign win_ok   = in_valid && (cur_col >= COL_TWO) && (cur_row >= ROW_TWO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
      end else begin
        col <= cur_col + COL_ONE;
        row <= cur_row;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffers and 3x3 shift windows; index order [layer][row][col], with
  // row 2 / col 2 being the newest sample. Layer 0 = lo, 1 = mid, 2 = hi.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]        din  [3];
  logic [DATA_W-1:0]        tap1 [3];
  logic [DATA_W-1:0]        tap2 [3];
  logic signed [DATA_W-1:0] win  [3][3][3];

  assign din[0] = dog_lo;
  assign din[1] = dog_mid;
  assign din[2] = dog_hi;

  for (genvar l = 0; l < 3; l++) begin : g_layer
    dog_line_buffer #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .ADDR_W (XW)
    ) u_lb (
      .clk   (clk),
      .wr_en (in_valid),
      .addr  (cur_col),
      .din   (din[l]),
      .tap1  (tap1[l]),
      .tap2  (tap2[l])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < 3; l++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win[l][r][c] <= '0;
    end else if (in_valid) begin
      for (int l = 0; l < 3; l++) begin
        for (int r = 0; r < 3; r++) begin
          win[l][r][0] <= win[l][r][1];
          win[l][r][1] <= win[l][r][2];
        end
        win[l][0][2] <= tap2[l];
        win[l][1][2] <= tap1[l];
        win[l][2][2] <= din[l];
      end
    end
  end

  // The window tag is a one-cycle pulse so a result leaves the pipe on time
  // even when the input stalls right after the accepting beat.
  logic          w_valid;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_valid <= 1'b0;
      w_x     <= '0;
      w_y     <= '0;
    end else begin
      w_valid <= win_ok;
      if (win_ok) begin
        w_x <= cur_col - COL_ONE;
        w_y <= cur_row - ROW_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: neighbour compares and saturated magnitude. The centre's own bit
  // in the 27-bit vectors is forced to 1 so a plain AND-reduce covers the 26
  // real neighbours.
  // --------------------------------------------------------------------------
  logic signed [DATA_W-1:0] centre;
  logic [26:0]              gt, lt;
  logic [DATA_W-1:0]        abs_c;

  assign centre = win[1][1][1];

  always_comb begin
    gt    = '0;
    lt    = '0;
    abs_c = DATA_W'(abs_sat(64'(centre), DATA_W));
    for (int l = 0; l < 3; l++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (l == 1 && r == 1 && c == 1) begin
            gt[l*9 + r*3 + c] = 1'b1;
            lt[l*9 + r*3 + c] = 1'b1;
          end else begin
            gt[l*9 + r*3 + c] = centre > win[l][r][c];
            lt[l*9 + r*3 + c] = centre < win[l][r][c];
          end
        end
      end
    end
  end

  logic              s1_valid;
  logic [26:0]       gt_q, lt_q;
  logic [DATA_W-1:0] abs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      gt_q     <= '0;
      lt_q     <= '0;
      abs_q    <= '0;
      kp_x     <= '0;
      kp_y     <= '0;
    end else begin
      s1_valid <= w_valid;
      if (w_valid) begin
        gt_q  <= gt;
        lt_q  <= lt;
        abs_q <= abs_c;
        kp_x  <= w_x;
        kp_y  <= w_y;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: decision, counting and end-of-frame marker.
  // --------------------------------------------------------------------------
  assign out_valid  = s1_valid;
  assign keypoint   = s1_valid & ((&gt_q) | (&lt_q)) & (abs_q > THR);
  assign frame_done = s1_valid && (kp_x == COL_END) && (kp_y == ROW_END);

  // A start-of-frame beat takes priority over a late result of the old frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kp_count <= '0;
    end else if (sof_beat) begin
      kp_count <= '0;
    end else if (keypoint && (kp_count != '1)) begin
      kp_count <= kp_count + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_dog_extrema_stream
// Brief  : Scoreboard bench for dog_extrema_stream on an 8x8 frame. The
//          driver pushes the hand-derived result of every window-producing
//          beat; a negedge monitor pops and compares whenever out_valid is
//          high, including the beat-to-result cycle distance.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dog_extrema_stream;

  localparam int DATA_W = 17;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int THRESH = 3;
  localparam int CNT_W  = 16;

  logic                     clk      = 1'b0;
  logic                     rst      = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_sof   = 1'b0;
  logic signed [DATA_W-1:0] dog_lo   = '0;
  logic signed [DATA_W-1:0] dog_mid  = '0;
  logic signed [DATA_W-1:0] dog_hi   = '0;
  logic                     out_valid;
  logic                     keypoint;
  logic [2:0]               kp_x;
  logic [2:0]               kp_y;
  logic [CNT_W-1:0]         kp_count;
  logic                     frame_done;

  dog_extrema_stream #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .dog_lo     (dog_lo),
    .dog_mid    (dog_mid),
    .dog_hi     (dog_hi),
    .out_valid  (out_valid),
    .keypoint   (keypoint),
    .kp_x       (kp_x),
    .kp_y       (kp_y),
    .kp_count   (kp_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; a cycle is identified by its closing edge.
  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  int n_checks = 0;
  int n_err    = 0;
  int fd_seen  = 0;

  typedef struct {
    logic kp;
    int   x;
    int   y;
    logic fd;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];

  // Stimulus case: the only non-zero samples sit at pixel (4,4).
  logic signed [DATA_W-1:0] mid_val = '0;
  logic signed [DATA_W-1:0] hi_val  = '0;
  logic                     kp_en   = 1'b0;
  bit                       gaps    = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_case(input int m, input int h, input bit en);
    mid_val = DATA_W'(m);
    hi_val  = DATA_W'(h);
    kp_en   = en;
  endtask

  // Called at posedge+1 with in_valid low; leaves in_valid low again.
  task automatic beat(input int x, input int y, input bit sof);
    exp_t e;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_sof   = sof;
    dog_lo   = '0;
    dog_mid  = (x == 4 && y == 4) ? mid_val : '0;
    dog_hi   = (x == 4 && y == 4) ? hi_val  : '0;
    if (x >= 2 && y >= 2) begin
      e.kp  = kp_en && (x == 5) && (y == 5);
      e.x   = x - 1;
      e.y   = y - 1;
      e.fd  = (x == IMG_W - 1) && (y == IMG_H - 1);
      e.cyc = pos_cnt + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_pixels(input int first, input int last, input bit sof_first);
    for (int i = first; i <= last; i++)
      beat(i % IMG_W, i / IMG_W, sof_first && (i == first));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_pending_windows"}, exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_out_valid"},  out_valid,  0);
    chk({name, "_keypoint"},   keypoint,   0);
    chk({name, "_kp_x"},       kp_x,       0);
    chk({name, "_kp_y"},       kp_y,       0);
    chk({name, "_kp_count"},   kp_count,   0);
    chk({name, "_frame_done"}, frame_done, 0);
  endtask

  task automatic full_frame(input string name, input int exp_cnt);
    fd_seen = 0;
    run_pixels(0, IMG_W * IMG_H - 1, 1'b1);
    drain(name);
    chk({name, "_kp_count"}, kp_count, exp_cnt);
    chk({name, "_frame_done_pulses"}, fd_seen, 1);
  endtask

  // Monitor: result must appear in the second cycle after the beat's cycle.
  always @(negedge clk) begin
    exp_t e;
    int   cyc_id;
    cyc_id = pos_cnt + 1;
    n_checks++;
    if (frame_done && !out_valid) begin
      n_err++;
      $display("FAIL frame_done_without_out_valid at cycle %0d", cyc_id);
    end
    if (out_valid) begin
      if (frame_done) fd_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_window: got kp=%0d x=%0d y=%0d, expected no window",
                 keypoint, kp_x, kp_y);
      end else begin
        e = exp_q.pop_front();
        if (keypoint !== e.kp || int'(kp_x) != e.x || int'(kp_y) != e.y ||
            frame_done !== e.fd || cyc_id != e.cyc + 2) begin
          n_err++;
          $display("FAIL window: got kp=%0d x=%0d y=%0d fd=%0d cycle=%0d, expected kp=%0d x=%0d y=%0d fd=%0d cycle=%0d",
                   keypoint, kp_x, kp_y, frame_done, cyc_id,
                   e.kp, e.x, e.y, e.fd, e.cyc + 2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // All-zero frame: 36 windows, no keypoints.
    set_case(0, 0, 1'b0);
    full_frame("zero", 0);

    // Isolated maximum, minimum, sub-threshold and tied-neighbour cases.
    set_case(10, 0, 1'b1);
    full_frame("max", 1);
    set_case(-10, 0, 1'b1);
    full_frame("min", 1);
    set_case(3, 0, 1'b0);
    full_frame("at_thresh", 0);
    set_case(10, 10, 1'b0);
    full_frame("tie_hi", 0);

    // Same maximum with random input gaps.
    gaps = 1'b1;
    set_case(10, 0, 1'b1);
    full_frame("gaps", 1);
    gaps = 1'b0;

    // Counters wrapped to (0,0); start a frame without sof, abort it with
    // sof at pixel 20, then complete the restarted frame.
    fd_seen = 0;
    set_case(0, 0, 1'b0);
    run_pixels(0, 19, 1'b0);
    chk("abort_kp_count_held", kp_count, 1);
    set_case(10, 0, 1'b1);
    run_pixels(0, 0, 1'b1);
    chk("abort_kp_count_cleared", kp_count, 0);
    run_pixels(1, IMG_W * IMG_H - 1, 1'b0);
    drain("abort");
    chk("abort_kp_count", kp_count, 1);
    chk("abort_frame_done_pulses", fd_seen, 1);

    // Reset in the middle of a most-negative-centre frame, then rerun it.
    set_case(-(2 ** (DATA_W - 1)), 0, 1'b1);
    run_pixels(0, 29, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk_zero_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    full_frame("sat_min", 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
